wb_arbiter: RTL and testbench

Writeback-side consumer of the memory/writeback pipeline latch. It decodes the latched instruction into a single register-file write and merges long-latency multdiv completions into the same write port through a 2-entry holding buffer. It stalls the pipeline only when the buffer is full and the pipeline also needs the port. It sits between the M/W latch outputs, the multdiv unit, and the register file's single write port.

---
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: decodes M/W into one regfile write, merges multdiv results via a 2-entry FIFO.
// Write port and stall are combinational; stall asserts only when the FIFO is full and the pipeline also writes.
module wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mw_instr,
  input  logic [31:0] mw_o,
  input  logic [31:0] mw_d,
  input  logic        mw_exception,
  input  logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic [31:0] md_status,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        stall,
  output logic [1:0]  md_pending
);
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] REG_EXC  = 5'd30;
  localparam logic [4:0] REG_RA   = 5'd31;

  logic        w_pipe_req;
  logic [4:0]  w_pipe_rd;
  logic [31:0] w_pipe_data;
  logic [4:0]  w_md_rd;
  logic [31:0] w_md_data;
  logic        w_md_vld;
  logic        w_full, w_empty, w_stall, w_deq, w_pipe_wr, w_md_discard, w_bypass, w_enq;
  logic [1:0]  w_valid_nxt;
  logic        w_unused;

  logic [4:0]  r_rd   [2];
  logic [31:0] r_data [2];
  logic [1:0]  r_valid;
  logic        r_head, r_tail;
  logic [1:0]  r_cnt;

  assign w_unused = ^mw_instr[21:0];

  always_comb begin
    w_pipe_req  = 1'b0;
    w_pipe_rd   = mw_instr[26:22];
    w_pipe_data = mw_o;
    if (mw_exception) begin
      w_pipe_req = 1'b1;
      w_pipe_rd  = REG_EXC;
    end else if (mw_instr != 32'h0) begin
      case (mw_instr[31:27])
        OP_RTYPE, OP_ADDI: w_pipe_req = 1'b1;
        OP_LW: begin
          w_pipe_req  = 1'b1;
          w_pipe_data = mw_d;
        end
        OP_JAL: begin
          w_pipe_req = 1'b1;
          w_pipe_rd  = REG_RA;
        end
        OP_SETX: begin
          w_pipe_req = 1'b1;
          w_pipe_rd  = REG_EXC;
        end
        default: w_pipe_req = 1'b0;
      endcase
    end
    if (w_pipe_rd == 5'd0) w_pipe_req = 1'b0;
  end

  assign w_md_rd   = md_exception ? REG_EXC : md_rd;
  assign w_md_data = md_exception ? md_status : md_result;
  assign w_md_vld  = md_ready && (w_md_rd != 5'd0);

  assign w_full       = (r_cnt == 2'd2);
  assign w_empty      = (r_cnt == 2'd0);
  assign w_stall      = w_pipe_req && w_full;
  assign w_pipe_wr    = w_pipe_req && !w_full;
  assign w_deq        = !w_empty && (!w_pipe_req || w_full);
  // Pipeline op is younger, so a same-cycle multdiv result to the same rd is already stale.
  assign w_md_discard = w_pipe_wr && (w_md_rd == w_pipe_rd);
  assign w_bypass     = w_md_vld && !w_pipe_req && w_empty;
  assign w_enq        = w_md_vld && !w_bypass && !w_md_discard;

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_pipe_wr) begin
      for (int i = 0; i < 2; i++) begin
        if (r_rd[i] == w_pipe_rd) w_valid_nxt[i] = 1'b0;
      end
    end
    if (w_deq) w_valid_nxt[r_head] = 1'b0;
    if (w_enq) w_valid_nxt[r_tail] = 1'b1;
  end

  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    if (w_pipe_wr) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = w_pipe_rd;
      data_writeReg    = w_pipe_data;
    end else if (w_deq) begin
      if (r_valid[r_head]) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = r_rd[r_head];
        data_writeReg    = r_data[r_head];
      end
    end else if (w_bypass) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = w_md_rd;
      data_writeReg    = w_md_data;
    end
    if (reset) begin
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = 5'd0;
      data_writeReg    = 32'h0;
    end
  end

  assign stall      = w_stall && !reset;
  assign md_pending = {1'b0, r_valid[0]} + {1'b0, r_valid[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 2'b00;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_valid <= w_valid_nxt;
      r_head  <= r_head ^ w_deq;
      r_tail  <= r_tail ^ w_enq;
      r_cnt   <= r_cnt + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  // Payload needs no reset: the valid bits alone decide whether it is ever used.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_tail]   <= w_md_rd;
      r_data[r_tail] <= w_md_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed test-plan cases plus randomized traffic against a queue model.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mw_instr = '0, mw_o = '0, mw_d = '0, md_result = '0, md_status = '0;
  logic        mw_exception = 1'b0, md_ready = 1'b0, md_exception = 1'b0;
  logic [4:0]  md_rd = '0;
  logic        ctrl_writeEnable, stall;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [1:0]  md_pending;

  wb_arbiter dut (
    .clk(clk), .reset(reset), .mw_instr(mw_instr), .mw_o(mw_o), .mw_d(mw_d),
    .mw_exception(mw_exception), .md_ready(md_ready), .md_rd(md_rd), .md_result(md_result),
    .md_exception(md_exception), .md_status(md_status), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .stall(stall),
    .md_pending(md_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        vld;
  } ent_t;
  ent_t mq[$];

  int n_chk = 0;
  int n_fail = 0;
  logic        s_we, s_stall;
  logic [4:0]  s_reg;
  logic [31:0] s_data;
  logic [1:0]  s_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 22'h15a5};
  endfunction

  function automatic void ref_dec(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] d,
                                  input logic exc, output logic req, output logic [4:0] rd,
                                  output logic [31:0] dat);
    req = 1'b1; rd = ins[26:22]; dat = o;
    case (ins[31:27])
      5'b00000, 5'b00101: ;
      5'b01000: dat = d;
      5'b00011: rd = 5'd31;
      5'b10101: rd = 5'd30;
      default: req = 1'b0;
    endcase
    if (ins == 32'h0) req = 1'b0;
    if (exc) begin req = 1'b1; rd = 5'd30; dat = o; end
    if (rd == 5'd0) req = 1'b0;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].vld) n++;
    return n;
  endfunction

  // Predicts this cycle's write port and stall, and advances the queue to its post-edge state.
  task automatic model(output logic e_we, output logic [4:0] e_reg, output logic [31:0] e_data,
                       output logic e_stall);
    logic preq, mvld;
    logic [4:0] prd;
    logic [31:0] pdat;
    ent_t m, h;
    ref_dec(mw_instr, mw_o, mw_d, mw_exception, preq, prd, pdat);
    m.rd = md_exception ? 5'd30 : md_rd;
    m.data = md_exception ? md_status : md_result;
    m.vld = 1'b1;
    mvld = md_ready && (m.rd != 5'd0);
    e_we = 1'b0; e_reg = '0; e_data = '0; e_stall = 1'b0;
    if (preq && mq.size() < 2) begin
      e_we = 1'b1; e_reg = prd; e_data = pdat;
      foreach (mq[i]) if (mq[i].rd == prd) mq[i].vld = 1'b0;
      if (mvld && m.rd != prd) mq.push_back(m);
    end else if (mq.size() > 0) begin
      e_stall = preq;
      h = mq.pop_front();
      if (h.vld) begin e_we = 1'b1; e_reg = h.rd; e_data = h.data; end
      if (mvld) mq.push_back(m);
    end else if (mvld) begin
      e_we = 1'b1; e_reg = m.rd; e_data = m.data;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] d,
                      input logic exc, input logic mrdy, input logic [4:0] mrd,
                      input logic [31:0] mres, input logic mexc, input logic [31:0] mst);
    logic e_we, e_stall;
    logic [4:0] e_reg;
    logic [31:0] e_data;
    mw_instr = ins; mw_o = o; mw_d = d; mw_exception = exc;
    md_ready = mrdy; md_rd = mrd; md_result = mres; md_exception = mexc; md_status = mst;
    #3;
    model(e_we, e_reg, e_data, e_stall);
    s_we = ctrl_writeEnable; s_reg = ctrl_writeReg; s_data = data_writeReg; s_stall = stall;
    check("we", s_we, e_we);
    if (e_we) begin
      check("reg", s_reg, e_reg);
      check("data", s_data, e_data);
    end
    check("stall", s_stall, e_stall);
    @(posedge clk);
    #1;
    s_pend = md_pending;
    check("pending", s_pend, live_cnt());
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [4:0] ops [6];
    logic [4:0] rds [10];
    logic [31:0] r_ins, r_o, r_d;
    logic r_exc;
    ops = '{5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101, 5'b00111};
    rds = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd30, 5'd31};

    // Outputs held low during reset even with requests present.
    mw_instr = mk(5'b00101, 5'd5); mw_o = 32'h10; md_ready = 1'b1; md_rd = 5'd9;
    #2;
    check("rst_we", ctrl_writeEnable, 1'b0);
    check("rst_reg", ctrl_writeReg, 5'd0);
    check("rst_data", data_writeReg, 32'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_pend", md_pending, 2'd0);
    mw_instr = '0; mw_o = '0; md_ready = 1'b0; md_rd = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Decode
    step(mk(5'b00101, 5'd5), 32'h10, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("addi_reg", s_reg, 5'd5); check("addi_data", s_data, 32'h10);
    step(mk(5'b01000, 5'd7), 32'h99, 32'hABCD, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("lw_data", s_data, 32'hABCD);
    step(mk(5'b00011, 5'd2), 32'h44, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("jal_reg", s_reg, 5'd31);
    step(mk(5'b00101, 5'd5), 32'h2, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("exc_reg", s_reg, 5'd30); check("exc_data", s_data, 32'h2);
    step(mk(5'b00000, 5'd0), 32'h7, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("rd0_we", s_we, 1'b0);

    // Bypass
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd9, 32'h55, 1'b0, 32'h0);
    check("byp_reg", s_reg, 5'd9); check("byp_data", s_data, 32'h55); check("byp_pend", s_pend, 2'd0);

    // Collision
    step(mk(5'b00000, 5'd3), 32'h333, 32'h0, 1'b0, 1'b1, 5'd4, 32'h1, 1'b0, 32'h0);
    check("col_pend1", s_pend, 2'd1);
    step(mk(5'b00000, 5'd3), 32'h333, 32'h0, 1'b0, 1'b1, 5'd4, 32'h2, 1'b0, 32'h0);
    check("col_pend2", s_pend, 2'd2);
    step(mk(5'b00000, 5'd3), 32'h333, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("col_stall", s_stall, 1'b1); check("col_reg4", s_reg, 5'd4); check("col_d1", s_data, 32'h1);
    step(mk(5'b00000, 5'd3), 32'h333, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("col_nostall", s_stall, 1'b0); check("col_reg3", s_reg, 5'd3);
    idle();
    check("col_drain_reg", s_reg, 5'd4); check("col_drain_d", s_data, 32'h2);

    // WAW
    step(mk(5'b00000, 5'd3), 32'h333, 32'h0, 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 32'h0);
    check("waw_pend1", s_pend, 2'd1);
    step(mk(5'b00000, 5'd6), 32'h600, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("waw_pend0", s_pend, 2'd0);
    idle();
    check("waw_stale", s_we, 1'b0);
    step(mk(5'b00101, 5'd8), 32'h800, 32'h0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b0, 32'h0);
    check("waw_same_d", s_data, 32'h800);
    idle();
    check("waw_same_none", s_we, 1'b0);

    // Multdiv exception
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd12, 32'hDEAD, 1'b1, 32'h5);
    check("mdexc_reg", s_reg, 5'd30); check("mdexc_data", s_data, 32'h5);

    // Randomized traffic; a stalled request is presented again unchanged.
    r_ins = '0; r_o = '0; r_d = '0; r_exc = 1'b0; s_stall = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!s_stall) begin
        r_ins = ($urandom_range(0, 3) == 0) ? 32'h0
              : {ops[$urandom_range(0, 5)], rds[$urandom_range(0, 9)], 22'($urandom)};
        r_o = $urandom; r_d = $urandom;
        r_exc = ($urandom_range(0, 15) == 0);
      end
      step(r_ins, r_o, r_d, r_exc, ($urandom_range(0, 1) == 1), rds[$urandom_range(0, 9)],
           $urandom, ($urandom_range(0, 7) == 0), $urandom);
    end

    // Reset mid-operation with two buffered entries
    while (mq.size() != 0) idle();
    step(mk(5'b00000, 5'd3), 32'h333, 32'h0, 1'b0, 1'b1, 5'd4, 32'hA1, 1'b0, 32'h0);
    step(mk(5'b00000, 5'd3), 32'h333, 32'h0, 1'b0, 1'b1, 5'd5, 32'hA2, 1'b0, 32'h0);
    check("mid_pend2", s_pend, 2'd2);
    #1 reset = 1'b1;
    #1;
    check("mid_we", ctrl_writeEnable, 1'b0);
    check("mid_stall", stall, 1'b0);
    check("mid_pend", md_pending, 2'd0);
    mq.delete();
    mw_instr = '0; md_ready = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      idle();
      check("post_rst_we", s_we, 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
